// File: rtl/arbitro_escrita_reg2.sv
// Round-robin write arbiter for a shared 2-bit register: one winner per grant,
// one-cycle ack, then the stored value is frozen for HOLD cycles.
module arbitro_escrita_reg2 #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 2,
    parameter int HOLD   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data_req,
    output logic [N_REQ-1:0]          ack,
    output logic [1:0]                grant_idx,
    output logic [DATA_W-1:0]         saida,
    output logic [DATA_W-1:0]         saida_negada,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLD_ST = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        found;

    // Rotating priority: scan from the slot after the last winner, wrapping.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = grant_idx;
        cand   = grant_idx;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = 2'((int'(grant_idx) + k) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = GRANT;
            GRANT:   state_next = HOLD_ST;
            HOLD_ST: if (cnt == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            saida     <= '0;
            grant_idx <= 2'(N_REQ - 1);
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        saida     <= data_req[winner*DATA_W +: DATA_W];
                        grant_idx <= winner;
                    end
                end
                GRANT:   cnt <= 4'(HOLD - 1);
                HOLD_ST: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Outputs decode registered state only, so they cannot glitch.
    always_comb begin
        ack = '0;
        if (state == GRANT) ack[grant_idx] = 1'b1;
        busy = (state != IDLE);
    end

    assign saida_negada = ~saida;

endmodule
